// File: rtl/logic_pipe_pkg.sv
// -----------------------------------------------------------------------------
// logic_pipe_pkg
// Shared types and constants for the registered AND/OR/XOR pipe.
//   DEF_WIDTH   : default operand width
//   RES_W       : width of one packed result triple at the default width
//   logic_res_t : packed {x, y, z} result triple at the default width
//   res_w()     : packed result width for an arbitrary operand width
// -----------------------------------------------------------------------------
package logic_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int RES_W     = 3 * DEF_WIDTH;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] x;
    logic [DEF_WIDTH-1:0] y;
    logic [DEF_WIDTH-1:0] z;
  } logic_res_t;

  // Parameterised modules pack {x, y, z} into one vector of this width
  function automatic int res_w(input int width);
    return 3 * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy counter and asynchronous-read storage so the
// head entry is visible in the cycle after it was written.
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write strobe and data (ignored while full)
//   pop        : read strobe, advances the head (ignored while empty)
//   dout       : head entry data
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset: stale entries are unreachable once the counter is 0
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/logic_pipe_unit.sv
// -----------------------------------------------------------------------------
// logic_pipe_unit
// Registered, flow-controlled bitwise AND/OR/XOR unit with an optional running
// XOR accumulator as operand b, buffered by a DEPTH-entry output FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready = FIFO not full)
//   in_a, in_b          : operands (in_b ignored when in_acc=1)
//   in_acc              : use acc_q as operand b for this beat
//   acc_clr             : clear accumulator, sampled every cycle
//   out_valid/out_ready : output handshake on the FIFO head
//   out_x/out_y/out_z   : AND / OR / XOR of head entry, zero when not valid
//   out_cnt             : FIFO occupancy
//   acc_q               : accumulator value
// -----------------------------------------------------------------------------
module logic_pipe_unit
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic [CW-1:0]    out_cnt,
  output logic [WIDTH-1:0] acc_q
);

  localparam int RES_BITS = res_w(WIDTH);

  logic [WIDTH-1:0]    acc_reg;
  logic [WIDTH-1:0]    acc_next;
  logic [WIDTH-1:0]    bsel;
  logic [WIDTH-1:0]    x_bits;
  logic [WIDTH-1:0]    y_bits;
  logic [WIDTH-1:0]    z_bits;
  logic [RES_BITS-1:0] res_in;
  logic [RES_BITS-1:0] res_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // Accumulate mode reads the registered accumulator, never this cycle's result
  assign bsel = in_acc ? acc_reg : in_b;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
    assign x_bits[gi] = in_a[gi] & bsel[gi];
    assign y_bits[gi] = in_a[gi] | bsel[gi];
    assign z_bits[gi] = in_a[gi] ^ bsel[gi];
  end

  assign res_in   = {x_bits, y_bits, z_bits};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Clear has priority over an accumulate beat landing in the same cycle
  always_comb begin
    acc_next = acc_reg;
    if (acc_clr)
      acc_next = '0;
    else if (push && in_acc)
      acc_next = z_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_reg <= '0;
    else        acc_reg <= acc_next;
  end

  sync_fifo #(
    .WIDTH (RES_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (res_in),
    .pop   (pop),
    .dout  (res_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (out_cnt)
  );

  assign out_valid = !fifo_empty;

  // Head storage is unreset, so mask it while nothing is valid
  assign out_x = out_valid ? res_head[3*WIDTH-1:2*WIDTH] : '0;
  assign out_y = out_valid ? res_head[2*WIDTH-1:WIDTH]   : '0;
  assign out_z = out_valid ? res_head[WIDTH-1:0]         : '0;
  assign acc_q = acc_reg;

endmodule
